// File: rtl/afe_pkg.sv
// Shared definitions for the AFE programming sequencer.
//   afe_state_e : sequencer FSM states
//   ADDR_*      : AFE register addresses written by the sequence
//   WORD_W      : width of one AFE serial word
//   afe_word()  : builds a write word {0, addr, 000, data}
package afe_pkg;

   localparam int WORD_W = 16;

   localparam logic [2:0] ADDR_CFG  = 3'd0;
   localparam logic [2:0] ADDR_GAIN = 3'd2;
   localparam logic [2:0] ADDR_OFF  = 3'd5;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LATCH,
      ST_SHIFT,
      ST_GAP,
      ST_RUN,
      ST_DRAIN
   } afe_state_e;

   function automatic logic [WORD_W-1:0] afe_word(input logic [2:0] addr,
                                                  input logic [8:0] data);
      return {1'b0, addr, 3'b000, data};
   endfunction

endpackage

// File: rtl/afe_sequencer_if.sv
// Serial programming bus of the AFE.
//   afe_sclk  : serial clock, idles low, AFE samples on rising edge
//   afe_sdata : serial data, MSB first
//   afe_sload : frame strobe, active low
// master = sequencer side, slave = AFE side.
interface afe_sequencer_if;
   logic afe_sclk;
   logic afe_sdata;
   logic afe_sload;

   modport master (output afe_sclk, output afe_sdata, output afe_sload);
   modport slave  (input  afe_sclk, input  afe_sdata, input  afe_sload);
endinterface

// File: rtl/afe_spi_tx.sv
// Serializer for one 16-bit AFE word.
//   clk_100M, nrst : clock, async active-low reset
//   start, word    : load and start a frame (ignored while a frame is active)
//   done           : high during the last cycle of a frame (sload rises at its end)
//   sclk/sdata/sload : registered AFE bus outputs
// sclk half-period is CLK_DIV clocks; data moves on sclk falling edges and
// bit 15 is presented together with the sload falling edge.
module afe_spi_tx
   import afe_pkg::*;
#(
   parameter int CLK_DIV = 4
) (
   input  logic              clk_100M,
   input  logic              nrst,
   input  logic              start,
   input  logic [WORD_W-1:0] word,
   output logic              done,
   output logic              sclk,
   output logic              sdata,
   output logic              sload
);

   localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

   logic              active_q, active_d;
   logic              sclk_q,   sclk_d;
   logic              sload_q,  sload_d;
   logic [7:0]        div_q,    div_d;
   logic [3:0]        bit_q,    bit_d;
   logic [WORD_W-1:0] shreg_q,  shreg_d;

   always_comb begin
      active_d = active_q;
      sclk_d   = sclk_q;
      sload_d  = sload_q;
      div_d    = div_q;
      bit_d    = bit_q;
      shreg_d  = shreg_q;
      done     = 1'b0;
      if (!active_q) begin
         div_d = '0;
         if (start) begin
            active_d = 1'b1;
            sload_d  = 1'b0;
            sclk_d   = 1'b0;
            bit_d    = '0;
            shreg_d  = word;
         end
      end else if (div_q == DIV_LAST) begin
         div_d = '0;
         if (!sclk_q) begin
            sclk_d = 1'b1;
         end else begin
            sclk_d = 1'b0;
            if (bit_q == 4'd15) begin
               // Last falling edge: close the frame with sclk already low.
               done     = 1'b1;
               active_d = 1'b0;
               sload_d  = 1'b1;
               shreg_d  = '0;
               bit_d    = '0;
            end else begin
               bit_d   = bit_q + 4'd1;
               shreg_d = {shreg_q[WORD_W-2:0], 1'b0};
            end
         end
      end else begin
         div_d = div_q + 8'd1;
      end
   end

   always_ff @(posedge clk_100M or negedge nrst) begin
      if (!nrst) begin
         active_q <= 1'b0;
         sclk_q   <= 1'b0;
         sload_q  <= 1'b1;
         div_q    <= '0;
         bit_q    <= '0;
         shreg_q  <= '0;
      end else begin
         active_q <= active_d;
         sclk_q   <= sclk_d;
         sload_q  <= sload_d;
         div_q    <= div_d;
         bit_q    <= bit_d;
         shreg_q  <= shreg_d;
      end
   end

   assign sclk  = sclk_q;
   assign sload = sload_q;
   assign sdata = shreg_q[WORD_W-1];

endmodule

// File: rtl/afe_sequencer.sv
// AFE programming sequencer: writes config, gain and offset words to the AFE
// whenever scanning is requested or the settings change, then enables the
// line-capture datapath.
//   clk_100M, nrst      : clock, async active-low reset
//   cont_en             : level request to scan
//   cont_gain, cont_off : live settings (gain [5:0], offset [8:0] used)
//   line_busy           : capture datapath is mid-line
//   afe                 : AFE serial bus (master side)
//   scan_run            : capture enable, high only in RUN
//   busy                : high outside IDLE and RUN
module afe_sequencer
   import afe_pkg::*;
#(
   parameter int         CLK_DIV  = 4,
   parameter int         GAP_CYC  = 8,
   parameter logic [8:0] CFG_DATA = 9'h0D8
) (
   input  logic              clk_100M,
   input  logic              nrst,
   input  logic              cont_en,
   input  logic [15:0]       cont_gain,
   input  logic [15:0]       cont_off,
   input  logic              line_busy,
   afe_sequencer_if.master   afe,
   output logic              scan_run,
   output logic              busy
);

   localparam int                GAP_W    = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
   localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'(GAP_CYC - 1);
   localparam logic [GAP_W-1:0]  GAP_ONE  = GAP_W'(1);

   afe_state_e        state_q,    state_d;
   logic [5:0]        gain_sh_q,  gain_sh_d;
   logic [8:0]        off_sh_q,   off_sh_d;
   logic [1:0]        idx_q,      idx_d;
   logic [GAP_W-1:0]  gap_q,      gap_d;
   logic              abort_q,    abort_d;
   logic              scan_run_q, scan_run_d;
   logic              busy_q,     busy_d;

   logic              mismatch;
   logic              tx_start;
   logic              tx_done;
   logic [WORD_W-1:0] tx_word;
   logic              unused_bits;

   assign unused_bits = ^{cont_gain[15:6], cont_off[15:9]};
   assign mismatch    = (cont_gain[5:0] != gain_sh_q) || (cont_off[8:0] != off_sh_q);

   always_comb begin
      state_d   = state_q;
      gain_sh_d = gain_sh_q;
      off_sh_d  = off_sh_q;
      idx_d     = idx_q;
      gap_d     = gap_q;
      abort_d   = abort_q;
      unique case (state_q)
         ST_IDLE: begin
            if (cont_en) state_d = ST_LATCH;
         end
         ST_LATCH: begin
            gain_sh_d = cont_gain[5:0];
            off_sh_d  = cont_off[8:0];
            idx_d     = '0;
            abort_d   = 1'b0;
            state_d   = ST_SHIFT;
         end
         ST_SHIFT: begin
            // A dropped request lets the current word finish, then stops.
            if (!cont_en) abort_d = 1'b1;
            if (tx_done) begin
               state_d = ST_GAP;
               gap_d   = '0;
            end
         end
         ST_GAP: begin
            if (gap_q == GAP_LAST) begin
               if (!cont_en || abort_q)  state_d = ST_IDLE;
               else if (idx_q != 2'd2) begin
                  idx_d   = idx_q + 2'd1;
                  state_d = ST_SHIFT;
               end
               else if (mismatch)        state_d = ST_LATCH;
               else                      state_d = ST_RUN;
            end else begin
               gap_d = gap_q + GAP_ONE;
            end
         end
         ST_RUN: begin
            if (!cont_en || mismatch) state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (!line_busy) state_d = cont_en ? ST_LATCH : ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      scan_run_d = (state_d == ST_RUN);
      busy_d     = !((state_d == ST_IDLE) || (state_d == ST_RUN));
   end

   // The serializer loads on the edge that enters SHIFT, so the word is built
   // from next-state values (shadows captured in LATCH are visible here).
   assign tx_start = (state_d == ST_SHIFT) && (state_q != ST_SHIFT);

   always_comb begin
      unique case (idx_d)
         2'd0:    tx_word = afe_word(ADDR_CFG,  CFG_DATA);
         2'd1:    tx_word = afe_word(ADDR_GAIN, {3'b000, gain_sh_d});
         default: tx_word = afe_word(ADDR_OFF,  off_sh_d);
      endcase
   end

   always_ff @(posedge clk_100M or negedge nrst) begin
      if (!nrst) begin
         state_q    <= ST_IDLE;
         gain_sh_q  <= '0;
         off_sh_q   <= '0;
         idx_q      <= '0;
         gap_q      <= '0;
         abort_q    <= 1'b0;
         scan_run_q <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         gain_sh_q  <= gain_sh_d;
         off_sh_q   <= off_sh_d;
         idx_q      <= idx_d;
         gap_q      <= gap_d;
         abort_q    <= abort_d;
         scan_run_q <= scan_run_d;
         busy_q     <= busy_d;
      end
   end

   afe_spi_tx #(.CLK_DIV(CLK_DIV)) u_tx (
      .clk_100M (clk_100M),
      .nrst     (nrst),
      .start    (tx_start),
      .word     (tx_word),
      .done     (tx_done),
      .sclk     (afe.afe_sclk),
      .sdata    (afe.afe_sdata),
      .sload    (afe.afe_sload)
   );

   assign scan_run = scan_run_q;
   assign busy     = busy_q;

endmodule
